// File: rtl/elapsed_pager_pkg.sv
// Shared types and constants for the elapsed-time pager.
package elapsed_pager_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    CONV = 2'd2,
    SHOW = 2'd3
  } state_t;

  localparam logic [3:0] BLANK = 4'hF;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/elapsed_pager_if.sv
// Button/clear inputs and page display outputs of the elapsed-time pager.
interface elapsed_pager_if #(
  parameter int PAGE_DIG = 3,
  parameter int IDX_W    = 2
);
  logic                    toggle_btn;
  logic                    clear;
  logic                    running;
  logic [4*PAGE_DIG-1:0]   page_bcd;
  logic [IDX_W-1:0]        page_idx;
  logic                    ovf;

  modport master (
    output toggle_btn, clear,
    input  running, page_bcd, page_idx, ovf
  );

  modport slave (
    input  toggle_btn, clear,
    output running, page_bcd, page_idx, ovf
  );
endinterface

// File: rtl/elapsed_pager_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, CNT_W cycles per conversion.
// The result register only changes on the final step, so an abort or reset
// never leaks a partial value.
module bin2bcd_seq
  import elapsed_pager_pkg::*;
#(
  parameter int CNT_W = 36,
  parameter int NDIG  = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    bin,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int SW = (clog2(CNT_W + 1) > 0) ? clog2(CNT_W + 1) : 1;

  logic              busy;
  logic [SW-1:0]     step;
  logic [CNT_W-1:0]  sh;
  logic [4*NDIG-1:0] work;
  logic [4*NDIG-1:0] adj;
  logic [4*NDIG-1:0] work_nxt;

  // Add-3 correction on every digit >= 5, then shift in the next binary bit.
  always_comb begin
    adj = work;
    for (int d = 0; d < NDIG; d++) begin
      if (work[4*d +: 4] >= 4'd5) adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
    end
    work_nxt = {adj[4*NDIG-2:0], sh[CNT_W-1]};
    done     = busy && (step == SW'(1));
  end

  // Conversion sequencer with step down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      step <= '0;
      sh   <= '0;
      work <= '0;
      bcd  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      step <= '0;
    end else if (start) begin
      busy <= 1'b1;
      step <= SW'(CNT_W);
      sh   <= bin;
      work <= '0;
    end else if (busy) begin
      sh   <= {sh[CNT_W-2:0], 1'b0};
      work <= work_nxt;
      step <= step - 1'b1;
      if (done) begin
        busy <= 1'b0;
        bcd  <= work_nxt;
      end
    end
  end

endmodule

// File: rtl/elapsed_pager.sv
// Elapsed-time counter with start/stop button and paged BCD readout.
// Optional build macro: ELAPSED_SAT_EN -- count saturates at all-ones
// instead of wrapping to zero.
//
// state | meaning
// STOP  | idle, count held, display blank
// RUN   | counting one per cycle, display blank
// CONV  | converting the snapshot to BCD, display blank
// SHOW  | cycling pages of the last snapshot, MS page first
module elapsed_pager
  import elapsed_pager_pkg::*;
#(
  parameter int CNT_W      = 36,
  parameter int NDIG       = 12,
  parameter int PAGE_DIG   = 3,
  parameter int PAGE_TICKS = 25_000_000,
  parameter int DEB_TICKS  = 500_000
) (
  input  logic           CLOCK_50,
  input  logic           reset_n,
  elapsed_pager_if.slave bus
);

  localparam int NPAGE = NDIG / PAGE_DIG;
  localparam int PW    = 4 * PAGE_DIG;
  localparam int IDX_W = (clog2(NPAGE) > 0) ? clog2(NPAGE) : 1;
  localparam int PT_W  = (clog2(PAGE_TICKS) > 0) ? clog2(PAGE_TICKS) : 1;
  localparam int DB_W  = (clog2(DEB_TICKS) > 0) ? clog2(DEB_TICKS) : 1;

  localparam logic [IDX_W-1:0] TOP_PAGE = IDX_W'(NPAGE - 1);
  localparam logic [PT_W-1:0]  PT_LOAD  = PT_W'(PAGE_TICKS - 1);
  localparam logic [DB_W-1:0]  DB_LOAD  = DB_W'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic              btn_s1;
  logic              btn_s2;
  logic              btn_db;
  logic [DB_W-1:0]   deb_cnt;
  logic              press;

  state_t            state;
  state_t            state_nxt;
  logic              conv_start;
  logic              conv_abort;
  logic              conv_done;
  logic [4*NDIG-1:0] conv_bcd;

  logic [CNT_W-1:0]  cnt;
  logic              ovf_q;
  logic [PT_W-1:0]   ptmr;
  logic [IDX_W-1:0]  pidx;
  logic [PW-1:0]     page_sel;

  // Synchronise the button and accept a level only after it has been stable.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      btn_db  <= 1'b1;
      deb_cnt <= DB_LOAD;
    end else begin
      btn_s1 <= bus.toggle_btn;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_db) begin
        deb_cnt <= DB_LOAD;
      end else if (deb_cnt == '0) begin
        btn_db  <= btn_s2;
        deb_cnt <= DB_LOAD;
      end else begin
        deb_cnt <= deb_cnt - 1'b1;
      end
    end
  end

  assign press = btn_db && !btn_s2 && (deb_cnt == '0);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= STOP;
    else          state <= state_nxt;
  end

  // Next state and converter handshake; clear overrides any press.
  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    conv_abort = 1'b0;
    if (bus.clear) begin
      state_nxt  = STOP;
      conv_abort = (state == CONV);
    end else begin
      case (state)
        STOP: if (press) state_nxt = RUN;
        RUN: begin
          if (press) begin
            state_nxt  = CONV;
            conv_start = 1'b1;
          end
        end
        CONV: begin
          if (press) begin
            state_nxt  = RUN;
            conv_abort = 1'b1;
          end else if (conv_done) begin
            state_nxt = SHOW;
          end
        end
        SHOW: if (press) state_nxt = RUN;
        default: state_nxt = STOP;
      endcase
    end
  end

  // Elapsed count; the stopping press cycle does not count so the held
  // value equals the snapshot handed to the converter.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clear) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (state == RUN && !press) begin
`ifdef ELAPSED_SAT_EN
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (cnt >= CNT_MAX - 1'b1) ovf_q <= 1'b1;
`else
      cnt <= cnt + 1'b1;
      if (cnt == CNT_MAX) ovf_q <= 1'b1;
`endif
    end
  end

  bin2bcd_seq #(
    .CNT_W (CNT_W),
    .NDIG  (NDIG)
  ) u_bin2bcd (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .start (conv_start),
    .abort (conv_abort),
    .bin   (cnt),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Page hold timer (down-counter) and page index, top page first.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ptmr <= '0;
      pidx <= '0;
    end else if (state_nxt == SHOW && state != SHOW) begin
      ptmr <= PT_LOAD;
      pidx <= TOP_PAGE;
    end else if (state_nxt == SHOW) begin
      if (ptmr == '0) begin
        ptmr <= PT_LOAD;
        pidx <= (pidx == '0) ? TOP_PAGE : pidx - 1'b1;
      end else begin
        ptmr <= ptmr - 1'b1;
      end
    end else begin
      ptmr <= '0;
      pidx <= '0;
    end
  end

  // Select the visible page; blank outside SHOW.
  always_comb begin
    page_sel = {PAGE_DIG{BLANK}};
    if (state == SHOW) begin
      for (int p = 0; p < NPAGE; p++) begin
        if (pidx == IDX_W'(p)) page_sel = conv_bcd[p*PW +: PW];
      end
    end
  end

  assign bus.running  = (state == RUN);
  assign bus.page_bcd = page_sel;
  assign bus.page_idx = pidx;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_elapsed_pager.sv
// Directed bench for elapsed_pager (CNT_W=10, NDIG=6, PAGE_DIG=3,
// PAGE_TICKS=4, DEB_TICKS=2). A press acts on the 4th rising edge after
// the button is driven low, so press_btn(gap) spaces two press edges by gap.
module tb_elapsed_pager;

  logic CLOCK_50 = 1'b0;
  logic reset_n;

  int n_chk  = 0;
  int n_fail = 0;

  elapsed_pager_if #(.PAGE_DIG(3), .IDX_W(1)) bus ();

  elapsed_pager #(
    .CNT_W      (10),
    .NDIG       (6),
    .PAGE_DIG   (3),
    .PAGE_TICKS (4),
    .DEB_TICKS  (2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press_btn(input int gap);
    bus.toggle_btn = 1'b0;
    cyc(3);
    bus.toggle_btn = 1'b1;
    cyc(gap - 3);
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_bcd"}, 32'(bus.page_bcd), 32'hFFF);
    chk({tag, "_idx"}, 32'(bus.page_idx), 32'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.toggle_btn = 1'b1;
    bus.clear      = 1'b0;
    #2;
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk_blank("rst");
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

    // one-cycle bounce is ignored
    bus.toggle_btn = 1'b0;
    cyc(1);
    bus.toggle_btn = 1'b1;
    cyc(6);
    chk("bounce_running", 32'(bus.running), 32'd0);

    // clean press, 123 counted cycles, press
    press_btn(124);
    chk("press_running", 32'(bus.running), 32'd1);
    chk_blank("run");
    press_btn(5);
    chk("conv_running", 32'(bus.running), 32'd0);
    chk_blank("conv");
    cyc(8);
    chk_blank("conv_last");
    cyc(1);
    chk("show_idx_hi", 32'(bus.page_idx), 32'd1);
    chk("show_bcd_hi", 32'(bus.page_bcd), 32'h000);
    cyc(4);
    chk("show_idx_lo", 32'(bus.page_idx), 32'd0);
    chk("show_bcd_lo", 32'(bus.page_bcd), 32'h123);
    cyc(3);
    chk("hold_idx_lo", 32'(bus.page_idx), 32'd0);
    cyc(1);
    chk("wrap_idx", 32'(bus.page_idx), 32'd1);
    chk("wrap_bcd", 32'(bus.page_bcd), 32'h000);
    chk("ovf_123", 32'(bus.ovf), 32'd0);

    // resume 9 more (132), convert, abort at conversion cycle 5, 19 more
    press_btn(10);
    press_btn(5);
    press_btn(20);
    chk("abort_running", 32'(bus.running), 32'd1);
    chk_blank("abort");
    press_btn(5);
    cyc(9);
    chk("resume_bcd_hi", 32'(bus.page_bcd), 32'h000);
    cyc(4);
    chk("resume_bcd_lo", 32'(bus.page_bcd), 32'h151);

    // clear and press on the same edge while showing
    bus.toggle_btn = 1'b0;
    cyc(3);
    bus.clear = 1'b1;
    cyc(1);
    bus.clear      = 1'b0;
    bus.toggle_btn = 1'b1;
    chk("clr_running", 32'(bus.running), 32'd0);
    chk_blank("clr");
    cyc(15);
    chk("clr_stay_running", 32'(bus.running), 32'd0);
    chk_blank("clr_stay");
    press_btn(8);
    press_btn(5);
    cyc(9);
    chk("clr_cnt_hi", 32'(bus.page_bcd), 32'h000);
    cyc(4);
    chk("clr_cnt_lo", 32'(bus.page_bcd), 32'h007);

    // 1030 counted cycles from zero
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    chk("ovf_cleared", 32'(bus.ovf), 32'd0);
    press_btn(1031);
    press_btn(5);
    cyc(9);
`ifdef ELAPSED_SAT_EN
    chk("ovf_bcd_hi", 32'(bus.page_bcd), 32'h001);
    cyc(4);
    chk("ovf_bcd_lo", 32'(bus.page_bcd), 32'h023);
`else
    chk("ovf_bcd_hi", 32'(bus.page_bcd), 32'h000);
    cyc(4);
    chk("ovf_bcd_lo", 32'(bus.page_bcd), 32'h006);
`endif
    chk("ovf_set", 32'(bus.ovf), 32'd1);

    // asynchronous reset while running
    press_btn(10);
    chk("pre_rst_running", 32'(bus.running), 32'd1);
    chk("pre_rst_ovf", 32'(bus.ovf), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_running", 32'(bus.running), 32'd0);
    chk("async_rst_ovf", 32'(bus.ovf), 32'd0);
    chk_blank("async_rst");
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    cyc(3);
    chk("post_rst_running", 32'(bus.running), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/elapsed_pager.md
ELAPSED_PAGER -- requirements
Module: elapsed_pager

Interface
REQ-001 SHALL have parameter CNT_W, default 36, elapsed-counter width in bits.
REQ-002 SHALL have parameter NDIG, default 12, BCD digits produced; multiple of PAGE_DIG; 10^NDIG > 2^CNT_W.
REQ-003 SHALL have parameter PAGE_DIG, default 3, digits shown per page.
REQ-004 SHALL have parameter PAGE_TICKS, default 25_000_000, clock cycles each page is held.
REQ-005 SHALL have parameter DEB_TICKS, default 500_000, cycles the button must be stable before it is accepted.
REQ-006 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 toggle_btn  in  1  raw, asynchronous, active-low start/stop button.
REQ-009 clear  in  1  synchronous clear of the count; active-high.
REQ-010 running  out  1  high while counting.
REQ-011 page_bcd  out  4*PAGE_DIG  digits of the current page, MS digit in MS nibble; 4'hF = blank.
REQ-012 page_idx  out  clog2(NDIG/PAGE_DIG)  current page number, 0 = least significant.
REQ-013 ovf  out  1  count reached all-ones since the last clear.

Function
REQ-014 SHALL pass toggle_btn through a 2-FF synchroniser, then accept a level change only after it holds DEB_TICKS consecutive cycles; an accepted falling edge is one press.
REQ-015 SHALL use states STOP, RUN, CONV, SHOW; a press in STOP, CONV or SHOW goes to RUN; a press in RUN goes to CONV.
REQ-016 SHALL increment the count by 1 per cycle in RUN only; running = (state==RUN).
REQ-017 On entering CONV, SHALL snapshot the count and start a sequential double-dabble conversion taking exactly CNT_W cycles, then go to SHOW.
REQ-018 In RUN, STOP and CONV, page_bcd SHALL be all 4'hF and page_idx SHALL be 0.
REQ-019 On entering SHOW, SHALL display the most significant page; every PAGE_TICKS cycles SHALL step to the next lower page, wrapping from page 0 to the top page.
REQ-020 A press during CONV SHALL abort the conversion and go to RUN, with the count continuing from its held value.
REQ-021 clear SHALL zero the count and ovf and go to STOP in any state; clear wins over a same-cycle press.
REQ-022 Pages SHALL hold the snapshot BCD until the next CONV completes, independent of later counting.

Reset
REQ-023 reset_n low SHALL asynchronously set: state=STOP, count=0, ovf=0, page_bcd all 4'hF, page_idx=0, debouncer idle (button released), page timer=0.
REQ-024 Reset mid-conversion or mid-debounce SHALL discard all partial results.

Configuration
REQ-025 With ELAPSED_SAT_EN defined, the count SHALL saturate at all-ones, setting ovf.
REQ-026 Without ELAPSED_SAT_EN, the count SHALL wrap to 0, setting ovf on the wrap cycle.
REQ-027 In both cases ovf SHALL stay set until clear or reset.

Structure
REQ-028 A shared package SHALL hold the state enum, the BLANK nibble constant (4'hF) and a clog2 function.
REQ-029 The conversion SHALL be a sub-module bin2bcd_seq with start/done handshake, parametrised by CNT_W and NDIG.

Verification
All scenarios use CNT_W=10, NDIG=6, PAGE_DIG=3, PAGE_TICKS=4, DEB_TICKS=2.
REQ-030 Press, run 123 cycles, press -> after 10 cycles page_idx=1 with page_bcd=000; 4 cycles later page_idx=0 with page_bcd=123; wraps back to page 1.
REQ-031 Button bounce shorter than 2 cycles -> no state change; a clean press -> running=1.
REQ-032 Run 1030 cycles -> with ELAPSED_SAT_EN shows 001023 and ovf=1; without it shows 000006 and ovf=1.
REQ-033 Press at conversion cycle 5 -> running=1, page_bcd blank, count continues from its snapshot value.
REQ-034 clear and press in the same cycle while in SHOW -> state STOP, count=0, running=0.
REQ-035 reset_n low while running -> outputs take reset values immediately, with no clock edge required.
